// File: rtl/mt9v034_word_framer.sv
// Word framer for the MT9V034 LVDS stream: finds the bit rotation that frames
// each 12-bit word, locks onto it, and decodes sync codes into a pixel stream.
module mt9v034_word_framer #(
   parameter int unsigned C_LockCount    = 16,
   parameter int unsigned C_ErrLimit     = 4,
   parameter logic [9:0]  C_FsCode       = 10'h3FF,
   parameter logic [9:0]  C_LsCode       = 10'h3FE,
   parameter logic [9:0]  C_LeCode       = 10'h3FD,
   parameter logic [9:0]  C_FeCode       = 10'h3FC,
   parameter int unsigned C_PixCntWidth  = 10,
   parameter int unsigned C_LineCntWidth = 10
) (
   input  logic                      RxClkDiv,
   input  logic                      RxRst,
   input  logic                      RxDataRdy,
   input  logic [11:0]               RxData,
   output logic                      Locked,
   output logic [3:0]                RotAmount,
   output logic [9:0]                PixData,
   output logic                      PixValid,
   output logic                      FrameStart,
   output logic                      LineStart,
   output logic                      LineEnd,
   output logic                      FrameEnd,
   output logic [C_PixCntWidth-1:0]  PixCount,
   output logic [C_LineCntWidth-1:0] LineCount,
   output logic                      SyncErr
);

   localparam int unsigned WORD_W = 12;
   localparam int unsigned PIX_W  = 10;
   localparam int unsigned ROT_W  = 4;
   localparam int unsigned GOOD_W = 8;
   localparam int unsigned BAD_W  = 4;

   localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(C_LockCount - 1);
   localparam logic [BAD_W-1:0]  ERR_LAST  = BAD_W'(C_ErrLimit - 1);
   localparam logic [ROT_W-1:0]  ROT_MAX   = ROT_W'(WORD_W - 1);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t state, state_nx;

   logic [1:0]               rst_pipe;
   logic                     rst_i;
   logic [GOOD_W-1:0]        good_cnt, good_nx;
   logic [BAD_W-1:0]         bad_cnt, bad_nx;
   logic                     in_frame, in_frame_nx;
   logic                     in_line, in_line_nx;
   logic [C_PixCntWidth-1:0] pix_idx, pix_idx_nx;

   logic                      locked_nx;
   logic [ROT_W-1:0]          rot_nx, rot_inc;
   logic [PIX_W-1:0]          pix_data_nx;
   logic                      pix_valid_nx, fs_nx, ls_nx, le_nx, fe_nx, se_nx;
   logic [C_PixCntWidth-1:0]  pix_count_nx;
   logic [C_LineCntWidth-1:0] line_count_nx;

   logic [2*WORD_W-1:0] dbl;
   logic [WORD_W-1:0]   word_rot;
   logic                frame_ok;
   logic [PIX_W-1:0]    pix;

   // Reset asserts immediately, releases two word clocks after RxRst drops.
   always_ff @(posedge RxClkDiv or posedge RxRst) begin
      if (RxRst) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_i = rst_pipe[1];

   // Left rotation by RotAmount; the upper half of the doubled word avoids any 12-bit shift.
   assign dbl      = {RxData, RxData} << RotAmount;
   assign word_rot = dbl[2*WORD_W-1:WORD_W];
   assign frame_ok = word_rot[WORD_W-1] & ~word_rot[0];
   assign pix      = word_rot[WORD_W-2:1];
   assign rot_inc  = (RotAmount == ROT_MAX) ? '0 : RotAmount + ROT_W'(1);

   always_comb begin
      state_nx      = state;
      good_nx       = good_cnt;
      bad_nx        = bad_cnt;
      in_frame_nx   = in_frame;
      in_line_nx    = in_line;
      pix_idx_nx    = pix_idx;
      rot_nx        = RotAmount;
      pix_data_nx   = PixData;
      pix_count_nx  = PixCount;
      line_count_nx = LineCount;
      pix_valid_nx  = 1'b0;
      fs_nx         = 1'b0;
      ls_nx         = 1'b0;
      le_nx         = 1'b0;
      fe_nx         = 1'b0;
      se_nx         = 1'b0;

      if (RxDataRdy) begin
         unique case (state)
            SEARCH: begin
               if (frame_ok) begin
                  if (good_cnt == LOCK_LAST) begin
                     state_nx = LOCKED;
                     good_nx  = '0;
                  end else begin
                     good_nx = good_cnt + GOOD_W'(1);
                  end
               end else begin
                  good_nx = '0;
                  rot_nx  = rot_inc;
               end
            end

            LOCKED: begin
               if (!frame_ok) begin
                  // Misframed words are never decoded; enough in a row drops lock.
                  if (bad_cnt == ERR_LAST) begin
                     state_nx    = SEARCH;
                     bad_nx      = '0;
                     rot_nx      = rot_inc;
                     se_nx       = in_frame;
                     in_frame_nx = 1'b0;
                     in_line_nx  = 1'b0;
                  end else begin
                     bad_nx = bad_cnt + BAD_W'(1);
                  end
               end else begin
                  bad_nx = '0;
                  if (pix == C_FsCode) begin
                     fs_nx         = 1'b1;
                     se_nx         = in_frame;
                     in_frame_nx   = 1'b1;
                     in_line_nx    = 1'b0;
                     line_count_nx = '0;
                  end else if (pix == C_LsCode) begin
                     if (in_frame) begin
                        ls_nx        = 1'b1;
                        se_nx        = in_line;
                        in_line_nx   = 1'b1;
                        pix_idx_nx   = '0;
                        pix_count_nx = '0;
                     end else begin
                        se_nx = 1'b1;
                     end
                  end else if (pix == C_LeCode) begin
                     if (in_line) begin
                        le_nx         = 1'b1;
                        in_line_nx    = 1'b0;
                        line_count_nx = LineCount + C_LineCntWidth'(1);
                     end else begin
                        se_nx = 1'b1;
                     end
                  end else if (pix == C_FeCode) begin
                     if (in_frame) begin
                        fe_nx       = 1'b1;
                        se_nx       = in_line;
                        in_frame_nx = 1'b0;
                        in_line_nx  = 1'b0;
                     end else begin
                        se_nx = 1'b1;
                     end
                  end else if (in_line) begin
                     pix_valid_nx = 1'b1;
                     pix_data_nx  = pix;
                     pix_count_nx = pix_idx;
                     pix_idx_nx   = pix_idx + C_PixCntWidth'(1);
                  end
               end
            end

            default: state_nx = SEARCH;
         endcase
      end

      locked_nx = (state_nx == LOCKED);
   end

   always_ff @(posedge RxClkDiv or posedge rst_i) begin
      if (rst_i) begin
         state      <= SEARCH;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         in_frame   <= 1'b0;
         in_line    <= 1'b0;
         pix_idx    <= '0;
         Locked     <= 1'b0;
         RotAmount  <= '0;
         PixData    <= '0;
         PixValid   <= 1'b0;
         FrameStart <= 1'b0;
         LineStart  <= 1'b0;
         LineEnd    <= 1'b0;
         FrameEnd   <= 1'b0;
         PixCount   <= '0;
         LineCount  <= '0;
         SyncErr    <= 1'b0;
      end else begin
         state      <= state_nx;
         good_cnt   <= good_nx;
         bad_cnt    <= bad_nx;
         in_frame   <= in_frame_nx;
         in_line    <= in_line_nx;
         pix_idx    <= pix_idx_nx;
         Locked     <= locked_nx;
         RotAmount  <= rot_nx;
         PixData    <= pix_data_nx;
         PixValid   <= pix_valid_nx;
         FrameStart <= fs_nx;
         LineStart  <= ls_nx;
         LineEnd    <= le_nx;
         FrameEnd   <= fe_nx;
         PixCount   <= pix_count_nx;
         LineCount  <= line_count_nx;
         SyncErr    <= se_nx;
      end
   end

endmodule
